// File: rtl/serial_adder_sched.sv
// serial_adder_sched: round-robin scheduler sharing one 2-bit serial adder between requesters,
// serialising latched operands MSB-first and deserialising the 3-bit result.
module serial_adder_sched #(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 8,
  parameter int FLUSH_CYC = 6,
  parameter int GAP_CYC   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] op_a,
  input  logic [2*NUM_REQ-1:0] op_b,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic [2:0]           sum,
  output logic                 busy,
  output logic                 add_en_i,
  output logic                 add_ina,
  output logic                 add_inb,
  input  logic                 add_en_o,
  input  logic                 add_out
);
  localparam int PW   = $clog2(NUM_REQ);
  localparam int CMAX = (TIMEOUT > FLUSH_CYC) ? ((TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC)
                                              : ((FLUSH_CYC > GAP_CYC) ? FLUSH_CYC : GAP_CYC);
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [2:0] {
    S_FLUSH, S_IDLE, S_SEND_MSB, S_SEND_LSB, S_WAIT_EN, S_CAP1, S_CAP2, S_GAP
  } state_t;
  localparam state_t S_AFTER = (GAP_CYC > 0) ? S_GAP : S_IDLE;
  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [PW-1:0]      r_ptr, r_cur, w_pick;
  logic [1:0]         r_a, r_b, r_sh;
  logic [2:0]         r_sum;
  logic [NUM_REQ-1:0] r_done, r_err, w_cur_oh;
  logic               w_found, w_timeout, w_flush_end, w_gap_end;
  assign w_timeout   = int'(r_cnt) >= TIMEOUT - 1;
  assign w_flush_end = int'(r_cnt) >= FLUSH_CYC - 1;
  assign w_gap_end   = int'(r_cnt) >= GAP_CYC - 1;
  assign w_cur_oh    = NUM_REQ'(1) << r_cur;
  // circular search for the first request at or after the round-robin pointer
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int j = 0; j < NUM_REQ; j++)
      if (!w_found && req[(int'(r_ptr) + j) % NUM_REQ]) begin
        w_found = 1'b1;
        w_pick  = PW'((int'(r_ptr) + j) % NUM_REQ);
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_FLUSH;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FLUSH:    w_next = w_flush_end ? S_IDLE : S_FLUSH;
      S_IDLE:     w_next = w_found ? S_SEND_MSB : S_IDLE;
      S_SEND_MSB: w_next = S_SEND_LSB;
      S_SEND_LSB: w_next = S_WAIT_EN;
      S_WAIT_EN:  w_next = add_en_o ? S_CAP1 : w_timeout ? S_AFTER : S_WAIT_EN;
      S_CAP1:     w_next = S_CAP2;
      S_CAP2:     w_next = S_AFTER;
      default:    w_next = w_gap_end ? S_IDLE : S_GAP;
    endcase
  end
  // adder drive and grant are decoded from state so reset clears them at once
  always_comb begin
    gnt      = (r_state == S_SEND_MSB) ? w_cur_oh : '0;
    add_en_i = r_state == S_SEND_MSB;
    add_ina  = (r_state == S_SEND_MSB) ? r_a[1] : (r_state == S_SEND_LSB) ? r_a[0] : 1'b0;
    add_inb  = (r_state == S_SEND_MSB) ? r_b[1] : (r_state == S_SEND_LSB) ? r_b[0] : 1'b0;
    busy     = rst_n && (r_state != S_IDLE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt  <= '0;
      r_ptr  <= '0;
      r_cur  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_sh   <= '0;
      r_sum  <= '0;
      r_done <= '0;
      r_err  <= '0;
    end else begin
      r_cnt  <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
      r_done <= '0;
      r_err  <= '0;
      if (r_state == S_IDLE && w_found) begin
        r_cur <= w_pick;
        r_a   <= op_a[2*w_pick +: 2];
        r_b   <= op_b[2*w_pick +: 2];
        r_ptr <= (int'(w_pick) == NUM_REQ - 1) ? '0 : w_pick + PW'(1);
      end
      if (r_state == S_WAIT_EN && add_en_o) r_sh[1] <= add_out;
      if (r_state == S_WAIT_EN && !add_en_o && w_timeout) r_err <= w_cur_oh;
      if (r_state == S_CAP1) r_sh[0] <= add_out;
      if (r_state == S_CAP2) begin
        r_sum  <= {r_sh, add_out};
        r_done <= w_cur_oh;
      end
    end
  assign done = r_done;
  assign err  = r_err;
  assign sum  = r_sum;
endmodule

// File: tb/tb_serial_adder_sched.sv
// tb_serial_adder_sched: scoreboard bench; instance 0 runs directed traffic,
// instance 1 (GAP_CYC=3) runs saturated traffic to check frame spacing.
module tb_serial_adder_sched;
  localparam int N  = 4;
  localparam int TO = 8;
  typedef struct { int idx; logic [2:0] sum; bit is_err; } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]   req [2], gnt [2], done [2], err [2];
  logic [2*N-1:0] op_a [2], op_b [2];
  logic [2:0]     sum [2];
  logic           busy [2], en_i [2], ina [2], inb [2];
  bit             mute [2];
  int checks = 0, failures = 0, cyc = 0, g_cyc = 0, g_last = -1;
  int again [N];
  int gq [$];
  exp_t q [$];
  logic [2:0] last_sum = '0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    logic eo = 1'b0, ao = 1'b0, ma = 1'b0, mb = 1'b0, la = 1'b0, lb = 1'b0;
    logic [2:0] ph = '0;
    logic [2:0] s;
    assign s = {1'b0, ma, la} + {1'b0, mb, lb};
    serial_adder_sched #(.NUM_REQ(N), .TIMEOUT(TO), .FLUSH_CYC(6), .GAP_CYC(3*g)) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req[g]), .op_a(op_a[g]), .op_b(op_b[g]),
      .gnt(gnt[g]), .done(done[g]), .err(err[g]), .sum(sum[g]), .busy(busy[g]),
      .add_en_i(en_i[g]), .add_ina(ina[g]), .add_inb(inb[g]), .add_en_o(eo), .add_out(ao));
    // reset-less 2-bit serial adder: MSB then LSB in, carry/s1/s0 out two cycles later
    always @(posedge clk)
      case (ph)
        3'd0: if (en_i[g]) begin ma <= ina[g]; mb <= inb[g]; ph <= 3'd1; end
        3'd1: begin la <= ina[g]; lb <= inb[g]; ph <= 3'd2; end
        3'd2: begin eo <= !mute[g]; ao <= s[2]; ph <= 3'd3; end
        3'd3: begin eo <= 1'b0; ao <= s[1]; ph <= 3'd4; end
        3'd4: begin ao <= s[0]; ph <= 3'd5; end
        default: begin ao <= 1'b0; ph <= 3'd0; end
      endcase
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input int idx);
    exp_t e;
    e.idx = idx;
    e.sum = {1'b0, op_a[0][2*idx +: 2]} + {1'b0, op_b[0][2*idx +: 2]};
    e.is_err = 1'b0;
    last_sum = e.sum;
    q.push_back(e);
  endtask
  task automatic push_err(input int idx);
    exp_t e;
    e.idx = idx;
    e.sum = last_sum;
    e.is_err = 1'b1;
    q.push_back(e);
  endtask
  // one cycle: sample at the falling edge, score instance 0, check instance 1 spacing
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      g_last = -1;
      return;
    end
    if (gnt[0] != '0) begin
      g_cyc = cyc;
      gq.push_back(cyc);
      chk("gnt", gnt[0], q.size() != 0 ? 32'(1) << q[0].idx : 32'd0);
    end
    if ((done[0] | err[0]) != '0) begin
      if (q.size() == 0) chk("unexpected_out", {done[0], err[0]}, 0);
      else begin
        e = q.pop_front();
        chk("done", done[0], e.is_err ? 32'd0 : 32'(1) << e.idx);
        chk("err", err[0], e.is_err ? 32'(1) << e.idx : 32'd0);
        chk("sum", sum[0], e.sum);
        chk("latency", cyc - g_cyc, e.is_err ? 2 + TO : 6);
        if (again[e.idx] > 0) again[e.idx]--;
        else req[0][e.idx] = 1'b0;
      end
    end
    if (en_i[1]) begin
      if (g_last >= 0) chk("gap_spacing", cyc - g_last, 10);
      g_last = cyc;
    end
  endtask
  task automatic wait_gnt(output int t);
    int n = 0;
    do begin tick(); n++; end while (gnt[0] == '0 && n < 40);
    chk("gnt_seen", gnt[0] != '0, 1);
    t = cyc;
  endtask
  task automatic wait_idle(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin tick(); n++; end
    chk("drain", q.size(), 0);
    q.delete();
    tick();
  endtask
  initial begin
    int t, rel;
    req[0] = '0; req[1] = '1;
    op_a[0] = '0; op_b[0] = '0; op_a[1] = 8'h9C; op_b[1] = 8'h63;
    mute[0] = 1'b0; mute[1] = 1'b0;
    foreach (again[i]) again[i] = 0;
    repeat (3) tick();
    chk("rst_outs", {gnt[0], done[0], err[0], sum[0], busy[0], en_i[0], ina[0], inb[0]}, 0);
    chk("rst_outs_gap", {gnt[1], done[1], err[1], sum[1], busy[1], en_i[1], ina[1], inb[1]}, 0);
    rst_n = 1'b1; rel = cyc;
    op_a[0] = 8'h03; op_b[0] = 8'h03; push(0); req[0][0] = 1'b1;
    tick();
    chk("busy_flush", busy[0], 1);
    wait_gnt(t);
    chk("flush_len", t - rel, 7);
    chk("ser_msb_11", {en_i[0], ina[0], inb[0]}, 3'b111);
    tick(); chk("ser_lsb_11", {en_i[0], ina[0], inb[0]}, 3'b011);
    tick(); chk("ser_quiet", {en_i[0], ina[0], inb[0]}, 3'b000);
    wait_idle(40);
    chk("busy_idle", busy[0], 0);
    op_a[0] = 8'h10; op_b[0] = 8'h20; push(2); req[0][2] = 1'b1;
    wait_gnt(t);
    chk("ser_msb_12", {en_i[0], ina[0], inb[0]}, 3'b101);
    tick(); chk("ser_lsb_12", {en_i[0], ina[0], inb[0]}, 3'b010);
    wait_idle(40);
    op_a[0] = 8'h00; op_b[0] = 8'h00; push(2); req[0][2] = 1'b1;
    wait_gnt(t);
    op_a[0] = '1; op_b[0] = '1;
    wait_idle(40);
    chk("sum_zero", sum[0], 3'b000);
    op_a[0] = 8'h80; op_b[0] = 8'h40; push(3); req[0][3] = 1'b1;
    wait_gnt(t);
    req[0][1] = 1'b1;
    tick(); tick();
    req[0][1] = 1'b0;
    wait_idle(40);
    op_a[0] = 8'b00_01_10_11; op_b[0] = 8'b11_10_01_11;
    push(0); push(1); push(2); push(3); push(0);
    again[0] = 1; gq.delete(); req[0] = '1;
    wait_idle(80);
    chk("rr_count", gq.size(), 5);
    for (int i = 1; i < gq.size(); i++) chk("rr_spacing", gq[i] - gq[i-1], 7);
    mute[0] = 1'b1; push_err(1); req[0][1] = 1'b1;
    wait_idle(40);
    mute[0] = 1'b0;
    op_a[0] = 8'h30; op_b[0] = 8'h20; push(2); req[0][2] = 1'b1;
    wait_idle(40);
    op_a[0] = 8'h80; op_b[0] = 8'h40; push(3); req[0][3] = 1'b1;
    wait_gnt(t);
    repeat (4) tick();
    chk("cap1_busy", busy[0], 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {gnt[0], done[0], err[0], sum[0], busy[0], en_i[0], ina[0], inb[0]}, 0);
    q.delete(); last_sum = '0;
    tick();
    rst_n = 1'b1; rel = cyc; push(3);
    repeat (6) begin tick(); chk("flush_quiet", en_i[0], 0); end
    wait_gnt(t);
    chk("flush_len_mid", t - rel, 7);
    wait_idle(40);
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
